// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for the 2-read/1-write register file: write port, two read ports, flash clear.
// The master drives addresses/data/clear; the slave (register file) returns registered read data.
interface reg_file_2r1w_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  logic              clr;
  logic              wr;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  d_in;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  d_out_a;
  logic [WIDTH-1:0]  d_out_b;
  logic              rd_valid_a;
  logic              rd_valid_b;

  modport master (
    output clr, wr, wr_addr, d_in, rd_addr_a, rd_addr_b,
    input  d_out_a, d_out_b, rd_valid_a, rd_valid_b
  );

  modport slave (
    input  clr, wr, wr_addr, d_in, rd_addr_a, rd_addr_b,
    output d_out_a, d_out_b, rd_valid_a, rd_valid_b
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// Parametrised DEPTH x WIDTH register file with one write port and two registered read ports,
// per-register written-since-clear valid bits, optional hard-wired zero register and write bypass.
module reg_file_2r1w #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter bit REG0_ZERO = 1'b0,
  parameter bit BYPASS    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  reg_file_2r1w_if.slave    bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]            mem [DEPTH];
  logic [DEPTH-1:0]            vld_mem;
  logic                        wr_en;
  logic [1:0][ADDR_W-1:0]      rd_addr;
  logic [1:0][WIDTH-1:0]       rd_data_p0;
  logic [1:0]                  vld_p0;
  logic [1:0][WIDTH-1:0]       rd_data_p1;
  logic [1:0]                  vld_p1;

  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < DEPTH;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return REG0_ZERO && (addr == '0);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'(addr);
  endfunction

  // Writes to out-of-range addresses or the hard-wired zero register never touch state.
  assign wr_en = bus.wr && addr_legal(bus.wr_addr) && !is_zero_reg(bus.wr_addr);

  assign rd_addr[0] = bus.rd_addr_a;
  assign rd_addr[1] = bus.rd_addr_b;

  // Stage p0: combinational read lookup with optional same-edge write forwarding.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_p0[p] = '0;
      vld_p0[p]     = 1'b0;
      if (addr_legal(rd_addr[p])) begin
        if (is_zero_reg(rd_addr[p])) begin
          vld_p0[p] = 1'b1;
        end else if (BYPASS && wr_en && (bus.wr_addr == rd_addr[p])) begin
          rd_data_p0[p] = bus.d_in;
          vld_p0[p]     = 1'b1;
        end else begin
          rd_data_p0[p] = mem[to_idx(rd_addr[p])];
          vld_p0[p]     = vld_mem[to_idx(rd_addr[p])];
        end
      end
    end
  end

  // Stage p1: storage update and registered read outputs; reset and clr both wipe everything.
  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      vld_mem    <= '0;
      rd_data_p1 <= '0;
      vld_p1     <= '0;
    end else begin
      if (wr_en) begin
        mem[to_idx(bus.wr_addr)]     <= bus.d_in;
        vld_mem[to_idx(bus.wr_addr)] <= 1'b1;
      end
      rd_data_p1 <= rd_data_p0;
      vld_p1     <= vld_p0;
    end
  end

  assign bus.d_out_a    = rd_data_p1[0];
  assign bus.d_out_b    = rd_data_p1[1];
  assign bus.rd_valid_a = vld_p1[0];
  assign bus.rd_valid_b = vld_p1[1];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed table-driven bench: two instances driven in lockstep, one default build
// (DEPTH=8, bypass, no zero register) and one with DEPTH=6, REG0_ZERO=1, BYPASS=0.
module tb_reg_file_2r1w;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr, wr;
  logic [2:0] wr_addr, ra, rb;
  logic [7:0] d_in;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  reg_file_2r1w_if #(.WIDTH(8), .ADDR_W(3)) bus0 ();
  reg_file_2r1w_if #(.WIDTH(8), .ADDR_W(3)) bus1 ();

  assign bus0.clr = clr;  assign bus0.wr = wr;  assign bus0.wr_addr = wr_addr;
  assign bus0.d_in = d_in; assign bus0.rd_addr_a = ra; assign bus0.rd_addr_b = rb;
  assign bus1.clr = clr;  assign bus1.wr = wr;  assign bus1.wr_addr = wr_addr;
  assign bus1.d_in = d_in; assign bus1.rd_addr_a = ra; assign bus1.rd_addr_b = rb;

  reg_file_2r1w #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .REG0_ZERO(1'b0), .BYPASS(1'b1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  reg_file_2r1w #(.WIDTH(8), .DEPTH(6), .ADDR_W(3), .REG0_ZERO(1'b1), .BYPASS(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  typedef struct {
    logic       r, c, w;
    logic [2:0] wa;
    logic [7:0] din;
    logic [2:0] ra, rb;
    logic [7:0] a0, b0, a1, b1;
    logic       va0, vb0, va1, vb1;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, c, w, input logic [2:0] wa, input logic [7:0] din,
                   input logic [2:0] ra_i, rb_i,
                   input logic [7:0] a0, input logic va0, input logic [7:0] b0, input logic vb0,
                   input logic [7:0] a1, input logic va1, input logic [7:0] b1, input logic vb1);
    vec_t t;
    t.r = r; t.c = c; t.w = w; t.wa = wa; t.din = din; t.ra = ra_i; t.rb = rb_i;
    t.a0 = a0; t.va0 = va0; t.b0 = b0; t.vb0 = vb0;
    t.a1 = a1; t.va1 = va1; t.b1 = b1; t.vb1 = vb1;
    vecs.push_back(t);
  endtask

  task automatic chk(input int id, input string port, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL step%0d %s: got valid=%b data=%h, expected valid=%b data=%h",
               id, port, act[8], act[7:0], exp[8], exp[7:0]);
    else
      passed++;
  endtask

  task automatic step(input logic r, c, w, input logic [2:0] wa, input logic [7:0] din,
                      input logic [2:0] ra_i, rb_i);
    reset = r; clr = c; wr = w; wr_addr = wa; d_in = din; ra = ra_i; rb = rb_i;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int id, input logic [8:0] a0, b0, a1, b1);
    chk(id, "dut0.a", {bus0.rd_valid_a, bus0.d_out_a}, a0);
    chk(id, "dut0.b", {bus0.rd_valid_b, bus0.d_out_b}, b0);
    chk(id, "dut1.a", {bus1.rd_valid_a, bus1.d_out_a}, a1);
    chk(id, "dut1.b", {bus1.rd_valid_b, bus1.d_out_b}, b1);
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; wr = 1'b0; wr_addr = '0; d_in = '0; ra = '0; rb = '0;

    // Reset for two cycles, then sweep every address on both ports.
    v(1,0,0, 0,8'h00, 0,0, 8'h00,0, 8'h00,0, 8'h00,0, 8'h00,0);
    v(1,0,0, 0,8'h00, 0,1, 8'h00,0, 8'h00,0, 8'h00,0, 8'h00,0);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] ia, ib;
      ia = 3'(i);
      ib = 3'(7 - i);
      v(0,0,0, 0,8'h00, ia,ib, 8'h00,0, 8'h00,0, 8'h00,(ia == 3'd0), 8'h00,(ib == 3'd0));
    end
    // Write A5 to reg 3, read it back next cycle against unwritten reg 4.
    v(0,0,1, 3,8'hA5, 0,0, 8'h00,0, 8'h00,0, 8'h00,1, 8'h00,1);
    v(0,0,0, 0,8'h00, 3,4, 8'hA5,1, 8'h00,0, 8'hA5,1, 8'h00,0);
    // Same-edge write/read of reg 5: forwarded only on the bypass build.
    v(0,0,1, 5,8'h3C, 5,5, 8'h3C,1, 8'h3C,1, 8'h00,0, 8'h00,0);
    v(0,0,0, 0,8'h00, 5,5, 8'h3C,1, 8'h3C,1, 8'h3C,1, 8'h3C,1);
    // Reg 0 writes (ignored on dut1) and writes to addresses 6/7 (illegal on dut1).
    v(0,0,1, 0,8'hEE, 0,7, 8'hEE,1, 8'h00,0, 8'h00,1, 8'h00,0);
    v(0,0,1, 7,8'h5A, 0,7, 8'hEE,1, 8'h5A,1, 8'h00,1, 8'h00,0);
    v(0,0,0, 0,8'h00, 7,0, 8'h5A,1, 8'hEE,1, 8'h00,0, 8'h00,1);
    v(0,0,1, 6,8'h66, 6,6, 8'h66,1, 8'h66,1, 8'h00,0, 8'h00,0);
    v(0,0,0, 0,8'h00, 6,6, 8'h66,1, 8'h66,1, 8'h00,0, 8'h00,0);
    // Fill regs 1..7 with 0x11..0x77 while watching reg 3 on port B.
    v(0,0,1, 1,8'h11, 1,3, 8'h11,1, 8'hA5,1, 8'h00,0, 8'hA5,1);
    v(0,0,1, 2,8'h22, 2,3, 8'h22,1, 8'hA5,1, 8'h00,0, 8'hA5,1);
    v(0,0,1, 3,8'h33, 3,3, 8'h33,1, 8'h33,1, 8'hA5,1, 8'hA5,1);
    v(0,0,1, 4,8'h44, 4,3, 8'h44,1, 8'h33,1, 8'h00,0, 8'h33,1);
    v(0,0,1, 5,8'h55, 5,3, 8'h55,1, 8'h33,1, 8'h3C,1, 8'h33,1);
    v(0,0,1, 6,8'h66, 6,3, 8'h66,1, 8'h33,1, 8'h00,0, 8'h33,1);
    v(0,0,1, 7,8'h77, 7,3, 8'h77,1, 8'h33,1, 8'h00,0, 8'h33,1);
    v(0,0,0, 0,8'h00, 2,7, 8'h22,1, 8'h77,1, 8'h22,1, 8'h00,0);
    // clr with a concurrent write to reg 2: write dropped, everything invalid.
    v(0,1,1, 2,8'hFF, 2,0, 8'h00,0, 8'h00,0, 8'h00,0, 8'h00,0);
    v(0,0,0, 0,8'h00, 2,0, 8'h00,0, 8'h00,0, 8'h00,0, 8'h00,1);
    v(0,0,0, 0,8'h00, 7,1, 8'h00,0, 8'h00,0, 8'h00,0, 8'h00,0);
    // Reset in the middle of a write burst.
    v(0,0,1, 1,8'h81, 1,2, 8'h81,1, 8'h00,0, 8'h00,0, 8'h00,0);
    v(0,0,1, 2,8'h82, 1,2, 8'h81,1, 8'h82,1, 8'h81,1, 8'h00,0);
    v(1,0,1, 3,8'h83, 1,2, 8'h00,0, 8'h00,0, 8'h00,0, 8'h00,0);
    v(0,0,1, 4,8'h84, 3,4, 8'h00,0, 8'h84,1, 8'h00,0, 8'h00,0);
    v(0,0,0, 0,8'h00, 4,1, 8'h84,1, 8'h00,0, 8'h84,1, 8'h00,0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].c, vecs[i].w, vecs[i].wa, vecs[i].din, vecs[i].ra, vecs[i].rb);
      chk_all(i, {vecs[i].va0, vecs[i].a0}, {vecs[i].vb0, vecs[i].b0},
                 {vecs[i].va1, vecs[i].a1}, {vecs[i].vb1, vecs[i].b1});
    end

    // Write then clear on the next edge; outputs must stay cleared while idle.
    step(0,0,1, 3'd2,8'h9C, 3'd2,3'd4);
    chk_all(100, {1'b1,8'h9C}, {1'b1,8'h84}, {1'b0,8'h00}, {1'b1,8'h84});
    step(0,1,0, 3'd0,8'h00, 3'd2,3'd4);
    chk_all(101, {1'b0,8'h00}, {1'b0,8'h00}, {1'b0,8'h00}, {1'b0,8'h00});
    for (int k = 0; k < 3; k++) begin
      step(0,0,0, 3'd0,8'h00, 3'd2,3'd0);
      chk_all(102 + k, {1'b0,8'h00}, {1'b0,8'h00}, {1'b0,8'h00}, {1'b1,8'h00});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
